// File: rtl/program_sequencer_pkg.sv
// Shared types for the program sequencer: step operation encoding.
package prog_seq_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NEXT   = 3'd0,
    OP_JMP    = 3'd1,
    OP_JMP_IF = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4,
    OP_HALT   = 3'd5
  } op_e;

endpackage

// File: rtl/program_sequencer_return_stack.sv
// LIFO of return addresses. Push is ignored when full, pop when empty;
// the caller decides what a refused request means.
module return_stack
  import prog_seq_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int W     = 4,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [LW-1:0] count;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  assign full   = (count == LW'(DEPTH));
  assign empty  = (count == {LW{1'b0}});
  assign level  = count;
  assign wr_idx = IW'(count);
  assign rd_idx = IW'(count - LW'(1));

  // Top-of-stack read; an empty stack presents zero rather than stale data.
  always_comb begin
    rdata = {W{1'b0}};
    if (!empty) begin
      rdata = mem[rd_idx];
    end else begin
      rdata = {W{1'b0}};
    end
  end

  // Occupancy counter; reset empties the stack without clearing storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= {LW{1'b0}};
    end else if (push && !full) begin
      count <= count + LW'(1);
    end else if (pop && !empty) begin
      count <= count - LW'(1);
    end else begin
      count <= count;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= wdata;
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Program counter and step sequencer: phase counter, step decode, next-pc
// selection, halt and sticky stack-error handling.
module program_sequencer
  import prog_seq_pkg::*;
#(
  parameter  int ADDR_W      = 4,
  parameter  int PHASE_W     = 4,
  parameter  int STACK_DEPTH = 4,
  parameter  int NUM_FLAGS   = 2,
  localparam int CW          = (NUM_FLAGS > 1) ? $clog2(NUM_FLAGS) : 1,
  localparam int LW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 resume,
  input  logic [OP_W-1:0]      op,
  input  logic [ADDR_W-1:0]    target,
  input  logic [CW-1:0]        cond_sel,
  input  logic [NUM_FLAGS-1:0] flags,
  output logic [ADDR_W-1:0]    pc,
  output logic [PHASE_W-1:0]   phase,
  output logic                 step,
  output logic                 cp,
  output logic                 halted,
  output logic [LW-1:0]        stack_level,
  output logic                 stack_err
);

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] st_top;
  logic              st_full;
  logic              st_empty;
  logic              push;
  logic              pop;
  logic              halt_set;
  logic              err_set;
  logic              flag_hit;

  assign step   = run && !halted && (phase == {PHASE_W{1'b1}});
  assign cp     = phase[PHASE_W-1];
  assign pc_inc = pc + ADDR_W'(1);

  // Selected condition flag; a cond_sel beyond the flag count never matches.
  always_comb begin
    flag_hit = 1'b0;
    for (int i = 0; i < NUM_FLAGS; i++) begin
      flag_hit = flag_hit | ((cond_sel == CW'(i)) & flags[i]);
    end
  end

  // Next-pc mux and stack/halt/error requests, active only on the step cycle.
  always_comb begin
    pc_next  = pc;
    push     = 1'b0;
    pop      = 1'b0;
    halt_set = 1'b0;
    err_set  = 1'b0;
    if (step) begin
      case (op)
        OP_JMP:    pc_next = target;
        OP_JMP_IF: pc_next = flag_hit ? target : pc_inc;
        OP_CALL: begin
          if (!st_full) begin
            push    = 1'b1;
            pc_next = target;
          end else begin
            pc_next = pc_inc;
            err_set = 1'b1;
          end
        end
        OP_RET: begin
          if (!st_empty) begin
            pop     = 1'b1;
            pc_next = st_top;
          end else begin
            pc_next = pc_inc;
            err_set = 1'b1;
          end
        end
        OP_HALT:   halt_set = 1'b1;
        default:   pc_next = pc_inc;
      endcase
    end else begin
      pc_next = pc;
    end
  end

  // Sequencer state: pc, phase, halt and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= {ADDR_W{1'b0}};
      phase     <= {PHASE_W{1'b0}};
      halted    <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      pc        <= pc_next;
      stack_err <= stack_err | err_set;
      if (halt_set) begin
        phase <= {PHASE_W{1'b0}};
      end else if (run && !halted) begin
        phase <= phase + PHASE_W'(1);
      end else begin
        phase <= phase;
      end
      if (halt_set) begin
        halted <= 1'b1;
      end else if (halted && resume) begin
        halted <= 1'b0;
      end else begin
        halted <= halted;
      end
    end
  end

  return_stack #(
    .DEPTH(STACK_DEPTH),
    .W    (ADDR_W)
  ) u_stack (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .wdata(pc_inc),
    .rdata(st_top),
    .full (st_full),
    .empty(st_empty),
    .level(stack_level)
  );

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: a reference model predicts pc, stack
// level, error and halt state for every step; results are compared after commit.
module tb_program_sequencer;
  import prog_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       resume;
  logic [2:0] op;
  logic [3:0] target;
  logic       cond_sel;
  logic [1:0] flags;
  logic [3:0] pc;
  logic [3:0] phase;
  logic       step;
  logic       cp;
  logic       halted;
  logic [2:0] stack_level;
  logic       stack_err;

  typedef struct {
    int pc;
    int lvl;
    int err;
    int halt;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] m_pc;
  int         m_stack[$];
  int         m_err;
  int         m_halt;

  program_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .resume     (resume),
    .op         (op),
    .target     (target),
    .cond_sel   (cond_sel),
    .flags      (flags),
    .pc         (pc),
    .phase      (phase),
    .step       (step),
    .cp         (cp),
    .halted     (halted),
    .stack_level(stack_level),
    .stack_err  (stack_err)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic model_apply(input logic [2:0] o, input logic [3:0] t,
                             input logic c, input logic [1:0] f);
    logic [3:0] inc;
    inc = m_pc + 4'd1;
    case (o)
      3'd1: m_pc = t;
      3'd2: m_pc = (int'(c) < 2 && f[c]) ? t : inc;
      3'd3: begin
        if (m_stack.size() < 4) begin
          m_stack.push_back(int'(inc));
          m_pc = t;
        end else begin
          m_pc  = inc;
          m_err = 1;
        end
      end
      3'd4: begin
        if (m_stack.size() > 0) begin
          m_pc = 4'(m_stack.pop_back());
        end else begin
          m_pc  = inc;
          m_err = 1;
        end
      end
      3'd5: m_halt = 1;
      default: m_pc = inc;
    endcase
  endtask

  // Present one operation, wait for its step cycle, predict, then compare after commit.
  task automatic run_step(input logic [2:0] o, input logic [3:0] t, input logic c,
                          input logic [1:0] f, input bit timed);
    int   cnt;
    exp_t e;
    cnt      = 0;
    op       = o;
    target   = t;
    cond_sel = c;
    flags    = f;
    while (!step && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (timed && cnt == 8) check_value("cp_low", int'(cp), 0);
      if (timed && cnt == 9) begin
        check_value("cp_high", int'(cp), 1);
        check_value("phase_mid", int'(phase), 8);
      end
    end
    if (!step) begin
      check_value("step_timeout", 0, 1);
      return;
    end
    if (timed) check_value("step_period", cnt, 16);
    model_apply(o, t, c, f);
    e.pc   = int'(m_pc);
    e.lvl  = m_stack.size();
    e.err  = m_err;
    e.halt = m_halt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_value("pc", int'(pc), e.pc);
    check_value("stack_level", int'(stack_level), e.lvl);
    check_value("stack_err", int'(stack_err), e.err);
    check_value("halted", int'(halted), e.halt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hits;
    int k;
    rst = 1'b1; run = 1'b0; resume = 1'b0;
    op = 3'd0; target = 4'd0; cond_sel = 1'b0; flags = 2'b00;
    m_pc = 4'd0; m_err = 0; m_halt = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check_value("rst_pc", int'(pc), 0);
    check_value("rst_phase", int'(phase), 0);
    check_value("rst_halted", int'(halted), 0);
    check_value("rst_level", int'(stack_level), 0);
    check_value("rst_err", int'(stack_err), 0);
    run = 1'b1;
    @(negedge clk);
    check_value("rst_hold_phase", int'(phase), 0);
    check_value("rst_step", int'(step), 0);
    rst = 1'b0;

    // 1: sequential stepping with wrap 15 -> 0
    run_step(3'd0, 4'd0, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 16; i++) run_step(3'd0, 4'd0, 1'b0, 2'b00, 1'b1);
    run = 1'b0;
    repeat (5) @(negedge clk);
    check_value("run0_phase", int'(phase), 0);
    check_value("run0_step", int'(step), 0);
    run = 1'b1;
    run_step(3'd0, 4'd0, 1'b0, 2'b00, 1'b0);

    // 2: conditional jumps and reserved opcodes
    run_step(3'd1, 4'd3, 1'b0, 2'b00, 1'b1);
    run_step(3'd2, 4'd9, 1'b0, 2'b01, 1'b1);
    run_step(3'd1, 4'd3, 1'b0, 2'b00, 1'b1);
    run_step(3'd2, 4'd9, 1'b1, 2'b01, 1'b1);
    run_step(3'd6, 4'd0, 1'b0, 2'b00, 1'b1);
    run_step(3'd7, 4'd0, 1'b0, 2'b00, 1'b1);

    // 3: call and return
    run_step(3'd1, 4'd3, 1'b0, 2'b00, 1'b1);
    run_step(3'd3, 4'd12, 1'b0, 2'b00, 1'b1);
    run_step(3'd4, 4'd0, 1'b0, 2'b00, 1'b1);

    // 4: overflow and underflow
    for (int i = 0; i < 5; i++) run_step(3'd3, 4'(i + 1), 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 5; i++) run_step(3'd4, 4'd0, 1'b0, 2'b00, 1'b1);

    // 5: halt and resume
    run_step(3'd1, 4'd7, 1'b0, 2'b00, 1'b1);
    run_step(3'd5, 4'd0, 1'b0, 2'b00, 1'b1);
    check_value("halt_phase", int'(phase), 0);
    op   = 3'd0;
    hits = 0;
    repeat (100) begin
      @(negedge clk);
      if (step) hits++;
    end
    check_value("halt_no_step", hits, 0);
    check_value("halt_pc", int'(pc), 7);
    resume = 1'b1;
    @(posedge clk);
    #1;
    resume = 1'b0;
    m_halt = 0;
    check_value("resume_halted", int'(halted), 0);
    check_value("resume_phase", int'(phase), 0);
    run_step(3'd0, 4'd0, 1'b0, 2'b00, 1'b1);

    // 6: asynchronous reset mid-step with a non-empty stack
    run_step(3'd3, 4'd2, 1'b0, 2'b00, 1'b1);
    run_step(3'd3, 4'd5, 1'b0, 2'b00, 1'b1);
    k = 0;
    while (phase != 4'd9 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_value("reach_phase9", int'(phase), 9);
    #2 rst = 1'b1;
    #1;
    check_value("arst_pc", int'(pc), 0);
    check_value("arst_phase", int'(phase), 0);
    check_value("arst_level", int'(stack_level), 0);
    check_value("arst_err", int'(stack_err), 0);
    check_value("arst_halted", int'(halted), 0);
    m_pc = 4'd0; m_err = 0; m_halt = 0;
    m_stack.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_value("restart_phase", int'(phase), 1);
    run_step(3'd0, 4'd0, 1'b0, 2'b00, 1'b0);
    run_step(3'd4, 4'd0, 1'b0, 2'b00, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
